// File: rtl/pcs_tx_arb.sv
// Two-requester round-robin MII transmit arbiter with nibble clock-enable and IPG enforcement.
// Optional half-duplex deferral on crs is enabled by defining PCS_ARB_DEFER_EN.
module pcs_tx_arb #(
    parameter int unsigned CE_DIV      = 5,
    parameter int unsigned IPG_NIBBLES = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_en,
    input  logic [7:0] req_d,
    input  logic [1:0] req_er,
    output logic [1:0] req_ack,
    output logic [1:0] grant,
    input  logic       link_status,
    input  logic       crs,
    output logic       tx_ce,
    output logic       tx_en,
    output logic [3:0] txd,
    output logic       tx_er
);

    localparam logic [3:0] DivLast = 4'(CE_DIV - 1);
    localparam logic [5:0] IpgLast = 6'(IPG_NIBBLES - 1);

    typedef enum logic [1:0] {StIdle, StXmit, StIpg} state_e;

    state_e     state_q, state_d;
    logic [3:0] div_q;
    logic [5:0] cnt_q, cnt_d;
    logic       prio_q, prio_d;
    logic [1:0] grant_q, grant_d;
    logic       tx_en_q, tx_en_d;
    logic [3:0] txd_q, txd_d;
    logic       tx_er_q, tx_er_d;
    logic       defer;
    logic       win;
    logic       owner;

`ifdef PCS_ARB_DEFER_EN
    assign defer = crs;
`else
    logic unused_crs;
    assign unused_crs = crs;
    assign defer      = 1'b0;
`endif

    assign tx_ce = (div_q == DivLast);
    assign grant = grant_q;
    assign tx_en = tx_en_q;
    assign txd   = txd_q;
    assign tx_er = tx_er_q;

    // Owner index is recoverable from the one-hot grant while transmitting.
    assign owner = grant_q[1];

    always_comb begin
        unique case (req_en)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = prio_q;
            default: win = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        grant_d = grant_q;
        tx_en_d = tx_en_q;
        txd_d   = txd_q;
        tx_er_d = tx_er_q;
        req_ack = 2'b00;

        if (!link_status) begin
            // Link loss overrides everything and parks the block in IPG.
            state_d = StIpg;
            cnt_d   = '0;
            grant_d = 2'b00;
            tx_en_d = 1'b0;
            txd_d   = 4'h0;
            tx_er_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (tx_ce && (req_en != 2'b00) && !defer) begin
                        state_d = StXmit;
                        grant_d = win ? 2'b10 : 2'b01;
                        req_ack = win ? 2'b10 : 2'b01;
                        prio_d  = ~win;
                        tx_en_d = 1'b1;
                        txd_d   = win ? req_d[7:4] : req_d[3:0];
                        tx_er_d = req_er[win];
                    end
                end
                StXmit: begin
                    if (tx_ce) begin
                        if (req_en[owner]) begin
                            req_ack = grant_q;
                            txd_d   = owner ? req_d[7:4] : req_d[3:0];
                            tx_er_d = req_er[owner];
                        end else begin
                            state_d = StIpg;
                            cnt_d   = '0;
                            grant_d = 2'b00;
                            tx_en_d = 1'b0;
                            txd_d   = 4'h0;
                            tx_er_d = 1'b0;
                        end
                    end
                end
                StIpg: begin
                    if (defer) begin
                        cnt_d = '0;
                    end else if (tx_ce) begin
                        if (cnt_q == IpgLast) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 6'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            state_q <= StIdle;
            cnt_q   <= '0;
            prio_q  <= 1'b0;
            grant_q <= 2'b00;
            tx_en_q <= 1'b0;
            txd_q   <= 4'h0;
            tx_er_q <= 1'b0;
        end else begin
            div_q   <= tx_ce ? 4'd0 : div_q + 4'd1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            grant_q <= grant_d;
            tx_en_q <= tx_en_d;
            txd_q   <= txd_d;
            tx_er_q <= tx_er_d;
        end
    end

endmodule

// File: tb/tb_pcs_tx_arb.sv
// Randomized scoreboard bench for pcs_tx_arb: frame-level reference model predicts acks,
// tx_ce and the registered MII outputs cycle by cycle; monitors pop and compare.
module tb_pcs_tx_arb;

    localparam int CE   = 5;
    localparam int IPG  = 24;
    localparam int NCYC = 20000;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_en;
    logic [7:0] req_d;
    logic [1:0] req_er;
    logic [1:0] req_ack;
    logic [1:0] grant;
    logic       link_status;
    logic       crs;
    logic       tx_ce;
    logic       tx_en;
    logic [3:0] txd;
    logic       tx_er;

    int checks = 0;
    int errors = 0;

    pcs_tx_arb #(.CE_DIV(CE), .IPG_NIBBLES(IPG)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_en     (req_en),
        .req_d      (req_d),
        .req_er     (req_er),
        .req_ack    (req_ack),
        .grant      (grant),
        .link_status(link_status),
        .crs        (crs),
        .tx_ce      (tx_ce),
        .tx_en      (tx_en),
        .txd        (txd),
        .tx_er      (tx_er)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {tx_ce, req_ack} for a cycle, and {grant, tx_en, txd, tx_er} after its edge.
    logic [2:0] q_comb[$];
    logic [7:0] q_reg[$];

    // Pending nibbles {er, d} of each requester's current frame.
    logic [4:0] rq0[$];
    logic [4:0] rq1[$];

    // Reference model: owner (-1 none), remaining gap nibbles, round-robin pointer.
    int         m_div, m_owner, m_gap, m_prio;
    logic [1:0] m_grant;
    logic       m_en, m_er;
    logic [3:0] m_d;

    initial begin
        logic [1:0] ack;
        logic       ce, defer;
        int         w, link_cnt, crs_cnt, len;

        rst_n = 1'b0; req_en = 2'b00; req_d = 8'h00; req_er = 2'b00;
        link_status = 1'b1; crs = 1'b0;
        link_cnt = 0; crs_cnt = 0;
        m_div = 0; m_owner = -1; m_gap = 0; m_prio = 0;
        m_grant = 2'b00; m_en = 1'b0; m_d = 4'h0; m_er = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc == 3) rst_n = 1'b1;
            if (cyc == 12000) rst_n = 1'b0;
            if (cyc == 12004) rst_n = 1'b1;

            if (link_cnt > 0) link_cnt--;
            else if ($urandom_range(1499) == 0) link_cnt = $urandom_range(25, 1);
            link_status = (link_cnt == 0);

            if (crs_cnt > 0) crs_cnt--;
            else if ($urandom_range(299) == 0) crs_cnt = $urandom_range(60, 1);
            crs = (crs_cnt > 0);

            // A requester may open a new frame only once the previous one has ended.
            if (cyc > 25) begin
                if (rq0.size() == 0 && m_owner != 0 && $urandom_range(29) == 0) begin
                    len = $urandom_range(8, 1);
                    for (int k = 0; k < len; k++)
                        rq0.push_back({($urandom_range(7) == 0), 4'($urandom)});
                end
                if (rq1.size() == 0 && m_owner != 1 && $urandom_range(29) == 0) begin
                    len = $urandom_range(8, 1);
                    for (int k = 0; k < len; k++)
                        rq1.push_back({($urandom_range(7) == 0), 4'($urandom)});
                end
            end

            req_en[0]   = (rq0.size() > 0);
            req_en[1]   = (rq1.size() > 0);
            req_d[3:0]  = (rq0.size() > 0) ? rq0[0][3:0] : 4'($urandom);
            req_er[0]   = (rq0.size() > 0) ? rq0[0][4] : 1'b0;
            req_d[7:4]  = (rq1.size() > 0) ? rq1[0][3:0] : 4'($urandom);
            req_er[1]   = (rq1.size() > 0) ? rq1[0][4] : 1'b0;

            #1;
            if (cyc == 12000) begin
                checks++;
                if (tx_en !== 1'b0 || grant !== 2'b00 || req_ack !== 2'b00) begin
                    errors++;
                    $display("FAIL async_reset: tx_en=%b grant=%b ack=%b required 0,00,00",
                             tx_en, grant, req_ack);
                end
            end

`ifdef PCS_ARB_DEFER_EN
            defer = crs;
`else
            defer = 1'b0;
`endif
            ack = 2'b00;
            ce  = 1'b0;
            if (!rst_n) begin
                m_div = 0; m_owner = -1; m_gap = 0; m_prio = 0;
                m_grant = 2'b00; m_en = 1'b0; m_d = 4'h0; m_er = 1'b0;
            end else begin
                ce = (m_div == CE - 1);
                if (!link_status) begin
                    m_owner = -1; m_gap = IPG;
                    m_grant = 2'b00; m_en = 1'b0; m_d = 4'h0; m_er = 1'b0;
                end else if (ce) begin
                    if (m_owner >= 0) begin
                        if (req_en[m_owner]) begin
                            ack[m_owner] = 1'b1;
                            m_d  = req_d[4*m_owner +: 4];
                            m_er = req_er[m_owner];
                        end else begin
                            m_owner = -1; m_gap = IPG;
                            m_grant = 2'b00; m_en = 1'b0; m_d = 4'h0; m_er = 1'b0;
                        end
                    end else if (m_gap > 0) begin
                        m_gap = defer ? IPG : m_gap - 1;
                    end else if (req_en != 2'b00 && !defer) begin
                        w = (req_en == 2'b11) ? m_prio : (req_en[1] ? 1 : 0);
                        ack[w]  = 1'b1;
                        m_owner = w;
                        m_prio  = 1 - w;
                        m_grant = (w == 1) ? 2'b10 : 2'b01;
                        m_en    = 1'b1;
                        m_d     = req_d[4*w +: 4];
                        m_er    = req_er[w];
                    end
                end else if (m_owner < 0 && m_gap > 0 && defer) begin
                    m_gap = IPG;
                end
                m_div = (m_div + 1) % CE;
            end

            q_comb.push_back({ce, ack});
            q_reg.push_back({m_grant, m_en, m_d, m_er});
            if (ack[0]) void'(rq0.pop_front());
            if (ack[1]) void'(rq1.pop_front());
        end

        repeat (3) @(negedge clk);
        if (q_reg.size() > 1) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d register expectations left, required at most 1",
                     q_reg.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Combinational outputs sampled mid-cycle, after the driver has settled this cycle's inputs.
    initial begin
        logic [2:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (q_comb.size() > 0) begin
                e = q_comb.pop_front();
                checks++;
                if ({tx_ce, req_ack} !== e) begin
                    errors++;
                    $display("FAIL ce_ack @%0t: tx_ce=%b req_ack=%b required tx_ce=%b req_ack=%b",
                             $time, tx_ce, req_ack, e[2], e[1:0]);
                end
            end
        end
    end

    // Registered outputs sampled just after the edge they were predicted for.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (q_reg.size() > 0) begin
                e = q_reg.pop_front();
                checks++;
                if ({grant, tx_en, txd, tx_er} !== e) begin
                    errors++;
                    $display("FAIL mii @%0t: grant=%b tx_en=%b txd=%h tx_er=%b required grant=%b tx_en=%b txd=%h tx_er=%b",
                             $time, grant, tx_en, txd, tx_er, e[7:6], e[5], e[4:1], e[0]);
                end
            end
        end
    end

endmodule
